// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
//
// Obstacle manager for the side-scrolling game. Holds NUM_PIPES pipe slots,
// moves every slot left by SPEED pixels once per frame, recycles pipes that
// leave the screen back to the right, and fetches a fresh gap height for the
// recycled pipe from the upstream height generator (req/valid handshake).
//
// Ports:
//   i_clk            system clock
//   i_reset_n        synchronous active-low reset
//   i_run            scrolling enable, sampled only while idle
//   i_frame_tick     one-cycle pulse per video frame
//   i_height         candidate gap top y from the height generator
//   i_height_valid   i_height is valid this cycle (used only while fetching)
//   o_height_req     request for a new height, held until i_height_valid
//   o_pipe_xr        per-slot right-edge x, slot i at bits [11i+10:11i]
//   o_pipe_gap_y     per-slot gap top y, slot i at bits [9i+8:9i]
//   o_score_pulse    one cycle when a pipe right edge crosses BIRD_X
//   o_frame_done     one cycle when a frame update completes
//   o_tick_missed    one cycle when a frame tick arrives while busy
// -----------------------------------------------------------------------------
module pipe_scroller #(
  parameter int NUM_PIPES   = 3,
  parameter int SCREEN_W    = 640,
  parameter int PIPE_W      = 52,
  parameter int SPACING     = 240,
  parameter int SPEED       = 2,
  parameter int BIRD_X      = 160,
  parameter int Y_MIN       = 40,
  parameter int Y_MAX       = 320,
  parameter int GAP_DEFAULT = 180
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_run,
  input  logic                     i_frame_tick,
  input  logic [8:0]               i_height,
  input  logic                     i_height_valid,
  output logic                     o_height_req,
  output logic [NUM_PIPES*11-1:0]  o_pipe_xr,
  output logic [NUM_PIPES*9-1:0]   o_pipe_gap_y,
  output logic                     o_score_pulse,
  output logic                     o_frame_done,
  output logic                     o_tick_missed
);

  localparam int               IDX_W    = (NUM_PIPES > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIPES - 1);
  localparam logic [10:0]      SPEED_X  = 11'(SPEED);
  localparam logic [10:0]      BIRD_XX  = 11'(BIRD_X);
  localparam logic [10:0]      RECYCLE  = 11'(NUM_PIPES * SPACING);
  localparam logic [8:0]       Y_MIN_H  = 9'(Y_MIN);
  localparam logic [8:0]       Y_MAX_H  = 9'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FETCH
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  logic [10:0] r_xr  [NUM_PIPES];
  logic [8:0]  r_gap [NUM_PIPES];

  logic r_height_req;
  logic r_score_pulse;
  logic r_frame_done;
  logic r_tick_missed;

  logic [10:0] w_cur_xr;
  logic [10:0] w_moved;
  logic [10:0] w_recycled;
  logic        w_off_screen;
  logic [8:0]  w_clamped;

  logic        w_xr_wr;
  logic [10:0] w_xr_val;
  logic        w_gap_wr;
  logic        w_req_next;
  logic        w_score;
  logic        w_done;
  logic        w_missed;

  // Datapath for the slot currently being scanned. The recycle sum wraps in
  // 11 bits, so a pipe at xr < SPEED lands at xr - SPEED + NUM_PIPES*SPACING
  // and the slots keep their exact spacing.
  always_comb begin
    w_cur_xr     = r_xr[r_idx];
    w_moved      = w_cur_xr - SPEED_X;
    w_recycled   = w_moved + RECYCLE;
    w_off_screen = (w_cur_xr <= SPEED_X);
    if (i_height < Y_MIN_H) begin
      w_clamped = Y_MIN_H;
    end else if (i_height > Y_MAX_H) begin
      w_clamped = Y_MAX_H;
    end else begin
      w_clamped = i_height;
    end
  end

  // Next-state and control. Leaving a slot (after a plain move or after a
  // completed fetch) either advances to the next slot or ends the frame.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_xr_wr      = 1'b0;
    w_xr_val     = w_moved;
    w_gap_wr     = 1'b0;
    w_req_next   = r_height_req;
    w_score      = 1'b0;
    w_done       = 1'b0;
    w_missed     = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_frame_tick && i_run) begin
          w_state_next = SCAN;
          w_idx_next   = '0;
        end
      end

      SCAN: begin
        w_missed = i_frame_tick;
        w_xr_wr  = 1'b1;
        if (w_off_screen) begin
          w_xr_val     = w_recycled;
          w_req_next   = 1'b1;
          w_state_next = FETCH;
        end else begin
          w_xr_val = w_moved;
          w_score  = (w_cur_xr > BIRD_XX) && (w_moved <= BIRD_XX);
          if (r_idx == LAST_IDX) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
            w_done       = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end

      FETCH: begin
        w_missed = i_frame_tick;
        if (i_height_valid) begin
          w_gap_wr   = 1'b1;
          w_req_next = 1'b0;
          if (r_idx == LAST_IDX) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
            w_done       = 1'b1;
          end else begin
            w_state_next = SCAN;
            w_idx_next   = r_idx + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Pipe slots and registered pulse outputs. Slots start just off the right
  // edge of the screen, one SPACING apart.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_xr[i]  <= 11'(SCREEN_W + PIPE_W + i * SPACING);
        r_gap[i] <= 9'(GAP_DEFAULT);
      end
      r_height_req  <= 1'b0;
      r_score_pulse <= 1'b0;
      r_frame_done  <= 1'b0;
      r_tick_missed <= 1'b0;
    end else begin
      if (w_xr_wr) begin
        r_xr[r_idx] <= w_xr_val;
      end
      if (w_gap_wr) begin
        r_gap[r_idx] <= w_clamped;
      end
      r_height_req  <= w_req_next;
      r_score_pulse <= w_score;
      r_frame_done  <= w_done;
      r_tick_missed <= w_missed;
    end
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign o_pipe_xr[g*11 +: 11]  = r_xr[g];
    assign o_pipe_gap_y[g*9 +: 9] = r_gap[g];
  end

  assign o_height_req  = r_height_req;
  assign o_score_pulse = r_score_pulse;
  assign o_frame_done  = r_frame_done;
  assign o_tick_missed = r_tick_missed;

endmodule
